serial_alu_ctrl: RTL
====================

Name: serial_alu_ctrl

Overview:
- Multi-cycle bit-serial ALU sequencer. Sits directly upstream of the 1-bit ALU slice and drives it one bit per cycle, LSB first.
- Feeds the slice with src bits, invert controls, operation and registered carry. Captures its result/cout into a shift register.
- Resolves SLT with a sign/overflow fix-up pass. Exposes a start/busy/done handshake to the datapath controller.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 2, and even when ALU_SERIAL_RADIX2_EN is defined.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous, active-high reset
- start_i  input  1  request; accepted only in IDLE
- src1_i  input  WIDTH  operand A, sampled on accept
- src2_i  input  WIDTH  operand B, sampled on accept
- ctrl_i  input  4  {A_invert, B_invert, operation[1:0]}, sampled on accept
- busy_o  output  1  high from the cycle after accept until done
- done_o  output  1  one-cycle pulse; result valid
- result_o  output  WIDTH  final result, held until the next accept
- zero_o  output  1  result_o == 0, held with result_o
- cout_o  output  1  carry out of bit WIDTH-1
- overflow_o  output  1  signed overflow for add/sub; 0 otherwise

Behaviour:
- Control encodings (ctrl_i): AND 0000, OR 0001, ADD 0010, SUB 0110, NOR 1100, SLT 0111. Other codes are processed as literal slice controls; no special handling.
- Slice carry-in:
  - bit 0 gets B_invert;
  - bit k>0 gets the registered cout of bit k-1.
- States:
  - IDLE: start_i=1 latches operands/ctrl, clears bit index and result shift register, and moves to RUN.
  - RUN: one bit per cycle. For SLT, the slice operation is forced to 2'b10, so the subtract sum is produced. The sum bit goes into a scratch register and the result bit is 0. After bit WIDTH-1, go to FIX if SLT, else DONE.
  - FIX (SLT only): less = sum[WIDTH-1] XOR overflow. result_o = {0..., less}. Go to DONE.
  - DONE: done_o=1 for exactly this cycle, busy_o=0, then go to IDLE.
- Latency from the accept edge to done_o: WIDTH+1 cycles for non-SLT, WIDTH+2 cycles for SLT.
- overflow = carry-in XOR carry-out of the MSB slice. It is reported only for ADD/SUB/SLT; it is 0 for logic ops.
- cout_o: MSB carry for arithmetic ops, 0 for logic ops.
- start_i while busy or in DONE: ignored, no queueing. start_i in the IDLE cycle directly after DONE is accepted.
- Reset values: all outputs 0, state IDLE, internal registers 0.
- Reset asserted mid-operation: aborts immediately, returns to IDLE, and the partial result is discarded.
- Operand inputs changing while busy: no effect (latched copies are used).

Optional Feature:
- Macro: ALU_SERIAL_RADIX2_EN.
- Defined: two slices instantiated and chained combinationally. Two bits are processed per RUN cycle, so RUN lasts WIDTH/2 cycles. Latency is WIDTH/2+1 cycles (+1 for SLT). Elaboration error if WIDTH is odd.
- Undefined: single slice, one bit per cycle as above.

Decomposition:
- Shared package alu_pkg holds:
  - the 4-bit ctrl encodings (CTRL_AND, CTRL_OR, CTRL_ADD, CTRL_SUB, CTRL_NOR, CTRL_SLT);
  - the state enum (ST_IDLE, ST_RUN, ST_FIX, ST_DONE);
  - the OP_SUM=2'b10 constant.
- One sub-module is natural: alu_bit_slice, the combinational 1-bit slice (invert muxes, and/or/sum/less select, carry). Instantiated once, or twice under radix-2.

Test Plan (WIDTH=8):
- ADD 0x7F+0x01, ctrl 0010 -> result_o 0x80, overflow_o 1, cout_o 0, zero_o 0; done_o exactly 9 cycles after accept.
- SUB 0x05-0x05, ctrl 0110 -> result_o 0x00, zero_o 1, cout_o 1, overflow_o 0.
- SLT signed:
  - 0xFE(-2) vs 0x03, ctrl 0111 -> result_o 0x01, done_o at cycle 10.
  - 0x80 vs 0x7F -> 0x01 (overflow path).
  - 0x03 vs 0xFE -> 0x00.
- NOR 0xF0,0x0F, ctrl 1100 -> result_o 0x00, zero_o 1. Second start_i pulse mid-run is ignored; one done_o pulse only.
- Reset asserted at cycle 4 of an ADD -> all outputs 0 asynchronously. Fresh AND 0xAA&0x0F afterwards -> 0x0A.
- Radix-2 build: ADD 0x7F+0x01 -> same results, done_o 5 cycles after accept.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the bit-serial ALU: slice control encodings, sequencer states
// and the slice operation code that selects the adder sum.
package alu_pkg;

    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_NOR = 4'b1100;
    localparam logic [3:0] CTRL_SLT = 4'b0111;

    localparam logic [1:0] OP_SUM = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_t;

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: operand invert muxes, full adder, and an
// and/or/sum/less result select.
module alu_bit_slice (
    input  logic       a,
    input  logic       b,
    input  logic       a_inv,
    input  logic       b_inv,
    input  logic [1:0] op,
    input  logic       cin,
    input  logic       less,
    output logic       result,
    output logic       cout
);
    logic a_eff;
    logic b_eff;
    logic sum;

    assign a_eff = a ^ a_inv;
    assign b_eff = b ^ b_inv;
    assign sum   = a_eff ^ b_eff ^ cin;
    assign cout  = (a_eff & b_eff) | (a_eff & cin) | (b_eff & cin);

    always_comb begin
        result = 1'b0;
        case (op)
            2'b00:   result = a_eff & b_eff;
            2'b01:   result = a_eff | b_eff;
            2'b10:   result = sum;
            default: result = less;
        endcase
    end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: drives alu_bit_slice LSB first, SLT resolved in a fix-up pass.
// ALU_SERIAL_RADIX2_EN: two chained slices, two bits per RUN cycle (WIDTH must be even).
//
// state   | meaning
// IDLE    | waiting for start_i; operands latched on accept
// RUN     | one slice step per cycle, LSB first
// FIX     | SLT only: less = msb sum XOR overflow
// DONE    | done_o pulse, result valid
module serial_alu_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o
);
`ifdef ALU_SERIAL_RADIX2_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH / STEP - 1);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("serial_alu_ctrl: WIDTH must be >= 2");
        end
        if (WIDTH % STEP != 0) begin : g_odd_width
            $error("serial_alu_ctrl: WIDTH must be even for the two-bit step");
        end
    endgenerate

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nx;
    logic [3:0]       ctrl_q;
    logic [CW-1:0]    cnt;
    logic             carry_q, msb_sum_q;
    logic [STEP-1:0]  ci, co, r_bits, r_keep;
    logic [1:0]       slice_op;
    logic             is_slt, is_arith, first, last, less;

    assign is_slt   = (ctrl_q == CTRL_SLT);
    assign is_arith = (ctrl_q[1:0] == OP_SUM) || is_slt;
    assign slice_op = is_slt ? OP_SUM : ctrl_q[1:0];
    assign first    = (cnt == LAST_CNT);
    assign last     = (cnt == '0);
    assign less     = msb_sum_q ^ overflow_o;

    // Bit 0 of the word takes B_invert as carry-in, later steps take the registered carry.
    assign ci[0] = first ? ctrl_q[2] : carry_q;

    for (genvar g = 0; g < STEP; g++) begin : g_slice
        alu_bit_slice u_slice (
            .a      (a_sh[g]),
            .b      (b_sh[g]),
            .a_inv  (ctrl_q[3]),
            .b_inv  (ctrl_q[2]),
            .op     (slice_op),
            .cin    (ci[g]),
            .less   (1'b0),
            .result (r_bits[g]),
            .cout   (co[g])
        );
        if (g > 0) begin : g_chain
            assign ci[g] = co[g-1];
        end
    end

    // SLT keeps only the sum MSB in scratch; its shifted result bits are zero.
    assign r_keep = is_slt ? '0 : r_bits;
    assign res_nx = WIDTH'({r_keep, res_sh} >> STEP);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        case (state)
            ST_IDLE: if (start_i) state_nx = ST_RUN;
            ST_RUN: begin
                busy_o = 1'b1;
                if (last) state_nx = is_slt ? ST_FIX : ST_DONE;
            end
            ST_FIX: begin
                busy_o   = 1'b1;
                state_nx = ST_DONE;
            end
            ST_DONE: begin
                done_o   = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_sh       <= '0;
            b_sh       <= '0;
            res_sh     <= '0;
            ctrl_q     <= '0;
            cnt        <= '0;
            carry_q    <= 1'b0;
            msb_sum_q  <= 1'b0;
            result_o   <= '0;
            zero_o     <= 1'b0;
            cout_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (start_i) begin
                    a_sh      <= src1_i;
                    b_sh      <= src2_i;
                    ctrl_q    <= ctrl_i;
                    cnt       <= LAST_CNT;
                    res_sh    <= '0;
                    carry_q   <= 1'b0;
                    msb_sum_q <= 1'b0;
                end
                ST_RUN: begin
                    a_sh    <= a_sh >> STEP;
                    b_sh    <= b_sh >> STEP;
                    res_sh  <= res_nx;
                    carry_q <= co[STEP-1];
                    cnt     <= cnt - 1'b1;
                    if (last) begin
                        msb_sum_q  <= r_bits[STEP-1];
                        cout_o     <= is_arith & co[STEP-1];
                        overflow_o <= is_arith & (ci[STEP-1] ^ co[STEP-1]);
                        if (!is_slt) begin
                            result_o <= res_nx;
                            zero_o   <= (res_nx == '0);
                        end
                    end
                end
                ST_FIX: begin
                    result_o <= {{(WIDTH-1){1'b0}}, less};
                    zero_o   <= ~less;
                end
                default: ;
            endcase
        end
    end

endmodule
